// File: rtl/fp_div.sv
// ---------------------------------------------------------------------------
// fp_div: iterative single-precision divider, y = a / b.
//
// This is the multi-cycle companion to fp_mul. It uses the same simplified
// format: the hidden 1 is always prepended, there is no NaN handling, and the
// exponent wraps modulo 256. A restoring divider produces one quotient bit per
// cycle. The result is then normalised and rounded to nearest-even.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset, aborts any operation
//   start  in   1   request, sampled only while idle; a/b captured with it
//   a      in  32   dividend
//   b      in  32   divisor
//   busy   out  1   high while dividing or rounding
//   done   out  1   one-cycle pulse; y valid from this cycle onward
//   y      out 32   quotient, held until the next done
// ---------------------------------------------------------------------------
module fp_div #(
    parameter int BIAS  = 127,
    parameter int QBITS = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] y
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DIVIDE   = 2'd1;
    localparam logic [1:0] ROUND    = 2'd2;
    localparam logic [4:0] LAST_CNT = 5'(QBITS - 1);

    logic [1:0]  state;
    logic        sign;
    logic [23:0] mb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [24:0] rem;
    logic [26:0] q;
    logic [4:0]  cnt;
    logic        za;
    logic        zb;

    // One restoring-division step. The partial remainder always stays
    // below 2*mb, so after a subtraction it fits in 24 bits and the
    // left shift cannot lose a set bit.
    logic        rem_ge;
    logic [23:0] rem_diff;
    logic [24:0] rem_next;

    assign rem_ge   = rem >= {1'b0, mb};
    assign rem_diff = 24'(rem - {1'b0, mb});
    assign rem_next = {(rem_ge ? rem_diff : rem[23:0]), 1'b0};

    // Normalise and round the finished quotient. The quotient of two
    // [1,2) mantissas lies in (0.5,2). q[26] is the integer bit. When it is
    // clear, the leading one sits one place lower and the exponent drops by
    // one. Exponent arithmetic is kept to 8 bits, which gives the same
    // modulo-256 wrap as wider arithmetic truncated to its low byte.
    logic [22:0] frac;
    logic        g_bit;
    logic        r_bit;
    logic        s_bit;
    logic        round_up;
    logic [23:0] frac_rnd;
    logic [7:0]  exp_pre;
    logic [7:0]  exp_fin;
    logic [31:0] y_next;

    always_comb begin
        if (q[26]) begin
            frac    = q[25:3];
            g_bit   = q[2];
            r_bit   = q[1];
            s_bit   = q[0] | (rem != 25'd0);
            exp_pre = ea - eb + 8'(BIAS);
        end else begin
            frac    = q[24:2];
            g_bit   = q[1];
            r_bit   = q[0];
            s_bit   = (rem != 25'd0);
            exp_pre = ea - eb + 8'(BIAS) - 8'd1;
        end
        round_up = g_bit & (r_bit | s_bit | frac[0]);
        frac_rnd = {1'b0, frac} + {23'd0, round_up};
        // A carry out of the fraction leaves frac_rnd[22:0] at zero and
        // bumps the exponent.
        exp_fin  = exp_pre + {7'd0, frac_rnd[23]};
        if (zb) begin
            y_next = {sign, 8'hFF, 23'h0};
        end else if (za) begin
            y_next = {sign, 31'h0};
        end else begin
            y_next = {sign, exp_fin, frac_rnd[22:0]};
        end
    end

    // Control and datapath registers. Operands are captured only from IDLE,
    // so a start seen while busy is ignored and not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sign  <= 1'b0;
            mb    <= '0;
            ea    <= '0;
            eb    <= '0;
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            za    <= 1'b0;
            zb    <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= a[31] ^ b[31];
                        mb    <= {1'b1, b[22:0]};
                        ea    <= a[30:23];
                        eb    <= b[30:23];
                        rem   <= {2'b01, a[22:0]};
                        q     <= '0;
                        cnt   <= '0;
                        za    <= (a[30:0] == 31'd0);
                        zb    <= (b[30:0] == 31'd0);
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    q   <= {q[25:0], rem_ge};
                    rem <= rem_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_CNT) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    y     <= y_next;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == DIVIDE) || (state == ROUND);

endmodule

// File: tb/tb_fp_div.sv
// ---------------------------------------------------------------------------
// tb_fp_div: self-checking bench for fp_div.
//
// A transaction-level reference model predicts busy, done and y. It tracks the
// latency of each accepted request and computes the quotient with plain integer
// division. A single compare process checks the DUT against the model on every
// falling edge. Directed operations pin known results and the handshake
// timing. Randomised operations, including ignored starts, cover the rest.
// ---------------------------------------------------------------------------
module tb_fp_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int checks   = 0;
    int failures = 0;

    fp_div #(.BIAS(127), .QBITS(27)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The run must always end, even if the DUT locks up.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference quotient computed from the number-format rules. The
    // mantissa ratio is scaled by 2^26 and divided with the integer operator.
    // The remainder supplies the sticky information.
    function automatic logic [31:0] model_div(input logic [31:0] x, input logic [31:0] d);
        logic           sgn;
        longint unsigned num;
        longint unsigned den;
        longint unsigned qt;
        longint unsigned frac;
        bit             g;
        bit             r;
        bit             st;
        int             e;
        sgn = x[31] ^ d[31];
        if (d[30:0] == 31'd0) return {sgn, 8'hFF, 23'h0};
        if (x[30:0] == 31'd0) return {sgn, 31'h0};
        num = 64'({1'b1, x[22:0]}) << 26;
        den = 64'({1'b1, d[22:0]});
        qt  = num / den;
        st  = (num % den) != 0;
        e   = int'(x[30:23]) - int'(d[30:23]) + 127;
        if (qt >= (64'd1 << 26)) begin
            frac = (qt >> 3) & 64'h7FFFFF;
            g    = qt[2];
            r    = qt[1];
            st   = st | qt[0];
        end else begin
            frac = (qt >> 2) & 64'h7FFFFF;
            g    = qt[1];
            r    = qt[0];
            e    = e - 1;
        end
        if (g && (r || st || frac[0])) frac = frac + 1;
        if (frac == 64'h800000) begin
            frac = 0;
            e    = e + 1;
        end
        return {sgn, e[7:0], frac[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            if (failures <= 40)
                $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [31:0] aa, input logic [31:0] bb);
        start = s;
        a     = aa;
        b     = bb;
    endtask

    // Expected outputs, updated once per rising edge from the sampled inputs.
    // An accepted request produces done exactly 28 edges later. Requests
    // arriving while one is outstanding are dropped.
    int          pend        = 0;
    logic [31:0] pend_y      = '0;
    logic        exp_busy    = 1'b0;
    logic        exp_done    = 1'b0;
    logic [31:0] exp_y       = '0;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pend        = 0;
            exp_done    = 1'b0;
            exp_y       = '0;
            model_valid = 1'b1;
        end else begin
            exp_done = 1'b0;
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    exp_y    = pend_y;
                    exp_done = 1'b1;
                end
            end else if (start) begin
                pend   = 28;
                pend_y = model_div(a, b);
            end
        end
        exp_busy = (pend > 0);
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("done", 32'(done), 32'(exp_done));
            checkOutput("y", y, exp_y);
            if (done && busy) checkOutput("done_and_busy", 32'(busy), 32'd0);
        end
    end

    // Issue one operation at the current falling edge and wait for done.
    // When inject_at is k >= 0, a second start is pulsed so that it is
    // sampled at edge E(k+1) and must be ignored. The task returns at the
    // falling edge that follows done, so a start issued immediately
    // afterwards lands on E29.
    task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] exp_res,
                          input string name, input int inject_at,
                          input logic [31:0] ia, input logic [31:0] ib);
        int lat;
        bit seen;
        applyStimulus(1'b1, aa, bb);
        lat  = 0;
        seen = 1'b0;
        while (lat <= 40) begin
            @(negedge clk);
            applyStimulus(1'b0, $urandom, $urandom);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (lat == inject_at) applyStimulus(1'b1, ia, ib);
            lat++;
        end
        checkOutput({name, " latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'd28);
        checkOutput({name, " y"}, y, exp_res);
        checkOutput({name, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    // Start an operation and reset it at E10. The operation must vanish:
    // outputs clear and no done appears afterwards.
    task automatic reset_mid_op();
        int done_count;
        applyStimulus(1'b1, 32'h40C00000, 32'h40000000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 32'h0);
            if (k == 9) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort y", y, 32'h0);
        done_count = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checkOutput("abort no_done", 32'(done_count), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          inj;
        int          sel;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);

        // Hand-computed results that pin the reference model itself.
        checkOutput("model 6/2", model_div(32'h40C00000, 32'h40000000), 32'h40400000);
        checkOutput("model 1/3", model_div(32'h3F800000, 32'h40400000), 32'h3EAAAAAB);
        checkOutput("model 1/1+ulp", model_div(32'h3F800000, 32'h3F800001), 32'h3F7FFFFE);
        checkOutput("model 0/0", model_div(32'h00000000, 32'h00000000), 32'h7F800000);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset y", y, 32'h0);
        @(negedge clk);

        $display("[TB] directed operations");
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, "6/2", -1, 0, 0);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1/3", -1, 0, 0);
        run_op(32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, "1/1+ulp", -1, 0, 0);
        run_op(32'hC0F00000, 32'h40200000, 32'hC0400000, "-7.5/2.5", -1, 0, 0);
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, "1/0", -1, 0, 0);
        run_op(32'h80000000, 32'h40000000, 32'h80000000, "-0/2", -1, 0, 0);
        run_op(32'h00000000, 32'h80000000, 32'hFF800000, "0/-0", -1, 0, 0);

        $display("[TB] start while busy, then back-to-back start");
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, "ignored", 4, 32'h3F800000, 32'h40400000);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "at E29", -1, 0, 0);

        $display("[TB] reset mid-operation");
        reset_mid_op();
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, "after abort", -1, 0, 0);

        $display("[TB] randomised operations");
        for (int i = 0; i < 150; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            sel = int'($urandom_range(0, 15));
            if (sel == 0) ra[30:0] = 31'd0;
            if (sel == 1) rb[30:0] = 31'd0;
            if (sel == 2) rb[22:0] = ra[22:0];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            inj = -1;
            if ($urandom_range(0, 3) == 0) inj = int'($urandom_range(0, 27));
            run_op(ra, rb, model_div(ra, rb), "rand", inj, $urandom, $urandom);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
